// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_access_pkg;

  localparam int WORD_DEF     = 8;
  localparam int ADDRESSL_DEF = 5;
  localparam int CNT_W        = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Strobe-length counter: counts ACCESS cycles and flags the last one.
module mem_wait_counter
  import mem_access_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic terminal_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign terminal_o = (count_q == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between datapath and the level-sensitive 8x32 memory.
// Optional read forwarding from the last write: MEM_ACCESS_FWD_EN.
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | strobe held for WAIT_CYCLES+1 cycles
//   DONE   | one-cycle response pulse
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int          WORD        = WORD_DEF,
  parameter int          ADDRESSL    = ADDRESSL_DEF,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDRESSL-1:0] req_addr,
  input  logic [WORD-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [WORD-1:0]     resp_rdata,
  output logic [ADDRESSL-1:0] mem_address,
  output logic [WORD-1:0]     mem_writeData,
  input  logic [WORD-1:0]     mem_readData,
  output logic                mem_memRead,
  output logic                mem_memWrite
);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDRESSL-1:0] addr_q, addr_d;
  logic [WORD-1:0]     wdata_q, wdata_d;
  logic [WORD-1:0]     rdata_q, rdata_d;
  logic                cnt_clr, cnt_en, cnt_term;

`ifdef MEM_ACCESS_FWD_EN
  logic                lw_valid_q, lw_valid_d;
  logic [ADDRESSL-1:0] lw_addr_q, lw_addr_d;
  logic [WORD-1:0]     lw_data_q, lw_data_d;
`endif

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .terminal_o (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
`ifdef MEM_ACCESS_FWD_EN
    lw_valid_d = lw_valid_q;
    lw_addr_d  = lw_addr_q;
    lw_data_d  = lw_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          state_d = ACCESS;
`ifdef MEM_ACCESS_FWD_EN
          if (req_write) begin
            lw_valid_d = 1'b1;
            lw_addr_d  = req_addr;
            lw_data_d  = req_wdata;
          end else if (lw_valid_q && (lw_addr_q == req_addr)) begin
            // Hit on the last write: answer without touching memory.
            rdata_d = lw_data_q;
            state_d = DONE;
          end
`endif
        end
      end
      ACCESS: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (cnt_term) begin
          if (!write_q) rdata_d = mem_readData;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ACCESS_FWD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lw_valid_q <= 1'b0;
      lw_addr_q  <= '0;
      lw_data_q  <= '0;
    end else begin
      lw_valid_q <= lw_valid_d;
      lw_addr_q  <= lw_addr_d;
      lw_data_q  <= lw_data_d;
    end
  end
`endif

  // Strobes depend only on registered state, so they drop with async reset.
  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_rdata    = rdata_q;
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;
  assign mem_memRead   = (state_q == ACCESS) && !write_q;
  assign mem_memWrite  = (state_q == ACCESS) &&  write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int W = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic [4:0] mem_address;
  logic [7:0] mem_writeData, mem_readData;
  logic       mem_memRead, mem_memWrite;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.WORD(8), .ADDRESSL(5), .WAIT_CYCLES(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_readData  (mem_readData),
    .mem_memRead   (mem_memRead),
    .mem_memWrite  (mem_memWrite)
  );

  always #5 clk = ~clk;

  // Memory: fixed seed contents overlaid by strobed writes.
  function automatic logic [7:0] seed(input int a);
    return 8'((a * 37 + 11) ^ 8'h5A);
  endfunction

  logic [7:0] wmem [32];
  bit         written [32];
  always @(posedge clk) begin
    if (mem_memWrite) begin
      wmem[mem_address]    <= mem_writeData;
      written[mem_address] <= 1'b1;
    end
  end
  assign mem_readData = written[mem_address] ? wmem[mem_address] : seed(int'(mem_address));

  // Reference model state
  logic [7:0] ref_mem [32];
  logic [7:0] exp_rdata;
  bit         lw_v;
  logic [4:0] lw_a;
  logic [7:0] lw_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input bit w, input logic [4:0] a, input logic [7:0] d);
    bit fwd;
    int cyc, rd_cnt, wr_cnt;
    bit got;
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    fwd = 1'b0;
`ifdef MEM_ACCESS_FWD_EN
    fwd = !w && lw_v && (lw_a == a);
`endif
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr  = 5'($urandom);
    req_wdata = 8'($urandom);
    if (w) begin
      ref_mem[a] = d;
      lw_v = 1'b1; lw_a = a; lw_d = d;
    end else begin
      exp_rdata = fwd ? lw_d : ref_mem[a];
    end
    cyc = 0; rd_cnt = 0; wr_cnt = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      check("strobe_excl", 32'(mem_memRead & mem_memWrite), 32'd0);
      if (mem_memRead)  rd_cnt++;
      if (mem_memWrite) wr_cnt++;
      if (mem_memRead || mem_memWrite) begin
        check("addr_stable", 32'(mem_address), 32'(a));
        if (w) check("wdata_stable", 32'(mem_writeData), 32'(d));
      end
      if (resp_valid) got = 1'b1;
    end
    check("resp_seen", 32'(got), 32'd1);
    check("resp_latency", 32'(cyc), fwd ? 32'd1 : 32'(W + 2));
    check("rd_strobe_cycles", 32'(rd_cnt), (!w && !fwd) ? 32'(W + 1) : 32'd0);
    check("wr_strobe_cycles", 32'(wr_cnt), w ? 32'(W + 1) : 32'd0);
    check("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("rdata_held", 32'(resp_rdata), 32'(exp_rdata));
    check("addr_held", 32'(mem_address), 32'(a));
  endtask

  initial begin
    int acc_cyc [$];
    int cyc;
    bit resp_since;
    logic [4:0] ba;

    for (int i = 0; i < 32; i++) ref_mem[i] = seed(i);
    exp_rdata = 8'h00; lw_v = 1'b0; lw_a = '0; lw_d = '0;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset mid-cycle during a read ACCESS with random inputs driven
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'($urandom); req_wdata = 8'($urandom);
    @(posedge clk);
    #3;
    req_valid = 1'($urandom); req_write = 1'($urandom);
    req_addr = 5'($urandom); req_wdata = 8'($urandom);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", 32'(resp_rdata), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_wdata", 32'(mem_writeData), 32'd0);
    check("rst_memread", 32'(mem_memRead), 32'd0);
    check("rst_memwrite", 32'(mem_memWrite), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_no_strobe", 32'({mem_memRead, mem_memWrite, resp_valid}), 32'd0);
      check("idle_ready", 32'(req_ready), 32'd1);
    end

    // Directed write then read of the same location
    do_req(1'b1, 5'h03, 8'hA5);
    do_req(1'b0, 5'h03, 8'h00);

    // req_valid held with alternating write addresses 1/2
    @(negedge clk);
    wait_ready();
    ba = 5'h01;
    req_valid = 1'b1; req_write = 1'b1; req_addr = ba; req_wdata = 8'h11;
    cyc = 0; resp_since = 1'b1;
    while (acc_cyc.size() < 4 && cyc < 60) begin
      check("b2b_excl", 32'(mem_memRead & mem_memWrite), 32'd0);
      if (resp_valid) resp_since = 1'b1;
      if (req_ready) begin
        check("b2b_resp_before_accept", 32'(resp_since), 32'd1);
        acc_cyc.push_back(cyc);
        resp_since = 1'b0;
        ref_mem[ba] = req_wdata;
        lw_v = 1'b1; lw_a = ba; lw_d = req_wdata;
        @(posedge clk);
        #1;
        ba = (ba == 5'h01) ? 5'h02 : 5'h01;
        req_addr = ba; req_wdata = req_wdata + 8'h11;
        if (acc_cyc.size() == 4) req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(W + 3));
    do_req(1'b0, 5'h01, 8'h00);
    do_req(1'b0, 5'h02, 8'h00);

    // Reset during second ACCESS cycle of a write
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h0A; req_wdata = 8'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("abort_strobe_before", 32'(mem_memWrite), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_strobe_drop", 32'(mem_memWrite), 32'd0);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    ref_mem[5'h0A] = 8'h77;
    exp_rdata = 8'h00;
    lw_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_quiet", 32'({resp_valid, mem_memRead, mem_memWrite}), 32'd0);
    end
    do_req(1'b0, 5'h0A, 8'h00);

    // Forwarding scenario (full path when forwarding is absent)
    do_req(1'b1, 5'h07, 8'h3C);
    do_req(1'b0, 5'h07, 8'h00);
    do_req(1'b0, 5'h08, 8'h00);

    // Random traffic biased toward a few addresses to produce hits
    for (int i = 0; i < 40; i++) begin
      logic [4:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      do_req(1'($urandom), ra, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer between the multicycle datapath/controller and the combinational, level-sensitive 8-bit x 32 data/instruction memory. It accepts one read or write request through a valid/ready handshake and holds the memory address and data stable. It drives mutually exclusive memRead/memWrite strobes for a programmable number of cycles. Read data is captured into a memory data register (MDR), and a one-cycle response is returned to the datapath.

Parameters:
WORD, 8, data width in bits; matches the memory word.
ADDRESSL, 5, address width in bits; matches the memory depth of 32.
WAIT_CYCLES, 1, extra cycles the strobe is held beyond the first; range 0..7.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDRESSL  request address.
req_wdata  input  WORD  write data.
resp_valid  output  1  one-cycle completion pulse for both reads and writes.
resp_rdata  output  WORD  MDR contents; holds the last read value.
mem_address  output  ADDRESSL  address to memory.
mem_writeData  output  WORD  write data to memory.
mem_readData  input  WORD  read data from memory.
mem_memRead  output  1  memory read strobe.
mem_memWrite  output  1  memory write strobe.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - req_ready=1; resp_valid=0, resp_rdata=0, mem_address=0, mem_writeData=0, mem_memRead=0, mem_memWrite=0.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1: latch req_addr into mem_address, req_wdata into mem_writeData, and req_write into an internal flag; counter=0; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - mem_memWrite = write flag; mem_memRead = !write flag. Exactly one strobe is high.
  - Each edge increments the counter. At the edge where counter==WAIT_CYCLES:
    - if read, capture mem_readData into resp_rdata;
    - go to DONE.
  - The strobe is therefore high for exactly WAIT_CYCLES+1 cycles, with address and data constant throughout.
- DONE:
  - Both strobes 0, req_ready=0, resp_valid=1 for exactly this one cycle.
  - Next edge goes to IDLE.
- Latency: request accepted at edge A; resp_valid is high between edges A+WAIT_CYCLES+1 and A+WAIT_CYCLES+2. Peak throughput is one request per WAIT_CYCLES+3 cycles.
- Writes leave resp_rdata unchanged.
- mem_address and mem_writeData hold their latched values outside ACCESS.
- Strobes are driven combinationally from registered state only, never from request inputs.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it sees req_ready=1 at a clock edge.
- Reset mid-ACCESS: strobes drop immediately (asynchronous). A write already strobed is not rolled back. No resp_valid is generated.
- WAIT_CYCLES=0: ACCESS lasts one cycle.

Optional Feature:
MEM_ACCESS_FWD_EN
- Defined:
  - Adds a last-write register (address, data, valid); valid clears on reset and updates on every accepted write.
  - A read whose address matches a valid last-write entry goes IDLE->DONE directly. resp_rdata is loaded with the stored data at the accept edge, and mem_memRead is never asserted.
  - Forwarded-read latency: resp_valid is high between edges A and A+1.
- Undefined: no forwarding logic; every read performs a full ACCESS.

Decomposition:
- Package mem_access_pkg:
  - state enum: IDLE=2'b00, ACCESS=2'b01, DONE=2'b10;
  - default constants WORD=8, ADDRESSL=5;
  - counter width constant 3.
- One sub-module, mem_wait_counter: 3-bit counter with clear, enable, and a terminal flag equal to (count==WAIT_CYCLES); reset is asynchronous, active-low.
- Everything else lives in a single always block for the FSM plus output assigns.

Test Plan:
- Assert rst=0 mid-cycle with random inputs -> all outputs reach their reset values immediately and req_ready=1; release, then idle 5 cycles -> no strobes.
- Write 8'hA5 to 5'h03 (WAIT_CYCLES=1) -> mem_memWrite high exactly 2 cycles with mem_address=3 and mem_writeData=A5; mem_memRead stays 0; one resp_valid pulse; resp_rdata stays 0.
- Read 5'h03, with the memory model returning A5 -> mem_memRead high 2 cycles; resp_rdata=8'hA5 on the resp_valid cycle and held afterwards.
- Hold req_valid continuously with alternating addresses 1/2 -> a second accept occurs only after resp_valid; the spacing between accepts is exactly 4 cycles; the strobes are never both high.
- Drop rst during the second ACCESS cycle of a write -> mem_memWrite falls within the same cycle; resp_valid is never asserted; the next request completes normally.
- With MEM_ACCESS_FWD_EN, write 8'h3C to 5'h07, then read 5'h07 -> mem_memRead never high; resp_valid one cycle after accept; resp_rdata=8'h3C. A read of 5'h08 takes the full path.
